axis_dmux_sched: RTL



---
 rtl/axis_dmux_pkg.sv | 19 +
 rtl/axis_dmux_cmd_fifo.sv | 69 ++++++
 rtl/axis_dmux_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axis_dmux_pkg.sv
// Shared types and constants for the AXI-Stream demux scheduler.
package axis_dmux_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    typedef struct packed {
        logic [SEL_W-1:0] dest;
        logic             drop;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/axis_dmux_cmd_fifo.sv
// Routing-command FIFO; flush clears it and overrides push/pop.
module axis_dmux_cmd_fifo
    import axis_dmux_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wdata,
    output logic [CMD_W-1:0] rdata_c,
    output logic             empty_c,
    output logic             not_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             not_full_q, not_full_d;
    logic             do_push_c, do_pop_c;

    always_comb begin
        do_push_c  = push && !flush && (cnt_q != CW'(DEPTH));
        do_pop_c   = pop && !flush && (cnt_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
        end
        // Ready is registered so it stays low through reset and rises one edge later.
        not_full_d = (cnt_d != CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            not_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            not_full_q <= not_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata_c  = mem_q[rd_ptr_q];
    assign empty_c  = (cnt_q == '0);
    assign not_full = not_full_q;

endmodule

// File: rtl/axis_dmux_sched.sv
// Per-frame demux scheduler: pops routing commands, drives demux control
// and counts delivered/dropped frames at each end of frame.
module axis_dmux_sched
    import axis_dmux_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [SEL_W-1:0]               cmd_dest,
    input  logic                           cmd_drop,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic                           enable,
    output logic                           drop,
    output logic [SEL_W-1:0]               sel,
    input  logic                           flush,
    input  logic                           stat_clear,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0]           drop_cnt,
    output logic                           busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               drop_q, drop_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] frame_cnt_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic               fifo_push_c, fifo_pop_c, fifo_empty_c, fifo_not_full;
    logic [CMD_W-1:0]   fifo_rdata_c;
    cmd_t               head_c;
    logic               eof_c, can_load_c;

    assign fifo_push_c = cmd_valid && fifo_not_full;
    assign head_c      = cmd_t'(fifo_rdata_c);

    axis_dmux_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (fifo_push_c),
        .pop      (fifo_pop_c),
        .wdata    ({cmd_dest, cmd_drop}),
        .rdata_c  (fifo_rdata_c),
        .empty_c  (fifo_empty_c),
        .not_full (fifo_not_full)
    );

    // Frame sequencing: load a command from IDLE or back-to-back at end of frame.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        drop_d     = drop_q;
        enable_d   = enable_q;
        fifo_pop_c = 1'b0;
        eof_c      = (state_q == ST_ACTIVE) && s_axis_tvalid && s_axis_tready && s_axis_tlast;
        can_load_c = !fifo_empty_c && !flush;
        case (state_q)
            ST_IDLE: begin
                if (can_load_c) begin
                    fifo_pop_c = 1'b1;
                    sel_d      = head_c.dest;
                    drop_d     = head_c.drop;
                    enable_d   = 1'b1;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (eof_c) begin
                    if (can_load_c) begin
                        fifo_pop_c = 1'b1;
                        sel_d      = head_c.dest;
                        drop_d     = head_c.drop;
                    end else begin
                        enable_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                enable_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ACTIVE);
    end

    // Statistics; a clear wins over a coincident end of frame.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (stat_clear) begin
            for (int p = 0; p < NUM_PORTS; p++) frame_cnt_d[p] = '0;
            drop_cnt_d = '0;
        end else if (eof_c) begin
            if (drop_q) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            else        frame_cnt_d[sel_q] = frame_cnt_q[sel_q] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            drop_q     <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) frame_cnt_q[p] <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            drop_q     <= drop_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            drop_cnt_q <= drop_cnt_d;
            for (int p = 0; p < NUM_PORTS; p++) frame_cnt_q[p] <= frame_cnt_d[p];
        end
    end

    always_comb begin
        frame_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) frame_cnt[p*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[p];
    end

    assign cmd_ready = fifo_not_full;
    assign enable    = enable_q;
    assign drop      = drop_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
